ni_router_local_input_buffer: RTL and testbench

- Credit-flow input buffer on the leaf router's local port. It sits directly downstream of the PE network interface output (out_data_valid/out_data) and upstream of the router's switch stage.
- Stores flits in a FIFO and presents the head flit first-word-fall-through.
- Returns one credit to the network interface per flit the switch consumes.
- Flags protocol violations, i.e. writes arriving while the buffer is full.

---
 rtl/ni_router_local_input_buffer.sv | 76 +++++++
 tb/tb_ni_router_local_input_buffer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ni_router_local_input_buffer.sv
// Credit-flow FWFT input buffer for the leaf router's local port.
// Returns one credit per consumed flit and flags writes that arrive while full.
module ni_router_local_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_data_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  upstream_credit,
  output logic                  out_data_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  read_en,
  output logic [PTR_WIDTH:0]    occupancy,
  output logic                  overflow_err
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [PTR_WIDTH:0]    r_occ;
  logic                  r_credit;
  logic                  r_ovf;

  logic w_empty;
  logic w_full;
  logic w_do_rd;
  logic w_do_wr;

  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == (PTR_WIDTH+1)'(DEPTH));
  assign w_do_rd = read_en && !w_empty;
  // A read in the same cycle frees the slot the write needs when full.
  assign w_do_wr = in_data_valid && (!w_full || w_do_rd);

  assign out_data_valid  = !w_empty;
  assign out_data        = r_mem[r_rd_ptr];
  assign occupancy       = r_occ;
  assign upstream_credit = r_credit;
  assign overflow_err    = r_ovf;

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_credit <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_credit <= w_do_rd;
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_occ <= r_occ + (PTR_WIDTH+1)'(1);
        2'b01:   r_occ <= r_occ - (PTR_WIDTH+1)'(1);
        default: r_occ <= r_occ;
      endcase
      if (in_data_valid && w_full && !w_do_rd) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ni_router_local_input_buffer.sv
// Directed bench for ni_router_local_input_buffer: fill/drain, full read+write,
// overflow, wrap-around streaming and asynchronous mid-operation reset.
module tb_ni_router_local_input_buffer;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 4;
  localparam int PTR_WIDTH  = 2;

  logic                  clk;
  logic                  rst;
  logic                  in_data_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  upstream_credit;
  logic                  out_data_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  read_en;
  logic [PTR_WIDTH:0]    occupancy;
  logic                  overflow_err;

  int n_assert;
  int n_fail;
  int credit_cnt;

  ni_router_local_input_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data_valid  (in_data_valid),
    .in_data        (in_data),
    .upstream_credit(upstream_credit),
    .out_data_valid (out_data_valid),
    .out_data       (out_data),
    .read_en        (read_en),
    .occupancy      (occupancy),
    .overflow_err   (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_flit(input logic [DATA_WIDTH-1:0] d);
    in_data_valid = 1'b1;
    in_data       = d;
    read_en       = 1'b0;
    tick();
    in_data_valid = 1'b0;
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    credit_cnt    = 0;
    rst           = 1'b0;
    in_data_valid = 1'b0;
    in_data       = '0;
    read_en       = 1'b0;

    // Reset then idle
    repeat (3) tick();
    chk("rst_occ", occupancy, 0);
    chk("rst_valid", out_data_valid, 0);
    rst = 1'b1;
    tick();
    chk("idle_occ", occupancy, 0);
    chk("idle_valid", out_data_valid, 0);
    chk("idle_credit", upstream_credit, 0);
    chk("idle_ovf", overflow_err, 0);

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      write_flit(32'hA0 + i);
      chk("fill_occ", occupancy, i + 1);
      chk("fill_head", out_data, 32'hA0);
      chk("fill_credit", upstream_credit, 0);
    end
    read_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", out_data, 32'hA0 + i);
      chk("drain_valid", out_data_valid, 1);
      tick();
      chk("drain_credit", upstream_credit, 1);
      chk("drain_occ", occupancy, 3 - i);
    end
    read_en = 1'b0;
    chk("drained_valid", out_data_valid, 0);
    tick();
    chk("drain_credit_end", upstream_credit, 0);
    chk("drain_occ_end", occupancy, 0);

    // Full with simultaneous read and write
    for (int i = 1; i <= 4; i++) write_flit(i);
    chk("fullrw_pre_occ", occupancy, 4);
    in_data_valid = 1'b1;
    in_data       = 5;
    read_en       = 1'b1;
    tick();
    in_data_valid = 1'b0;
    read_en       = 1'b0;
    chk("fullrw_head", out_data, 2);
    chk("fullrw_occ", occupancy, 4);
    chk("fullrw_ovf", overflow_err, 0);
    chk("fullrw_credit", upstream_credit, 1);
    tick();
    chk("fullrw_single_pulse", upstream_credit, 0);
    read_en = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("fullrw_drain_head", out_data, i);
      tick();
    end
    read_en = 1'b0;
    chk("fullrw_drain_occ", occupancy, 0);
    tick();

    // Overflow
    for (int i = 0; i < 4; i++) write_flit(32'h10 + i);
    in_data_valid = 1'b1;
    in_data       = 32'hFF;
    tick();
    in_data_valid = 1'b0;
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_occ", occupancy, 4);
    chk("ovf_credit", upstream_credit, 0);
    chk("ovf_head", out_data, 32'h10);
    read_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_head", out_data, 32'h10 + i);
      tick();
    end
    read_en = 1'b0;
    chk("ovf_drain_valid", out_data_valid, 0);
    chk("ovf_sticky", overflow_err, 1);
    tick();

    // Wrap-around streaming; the first read hits an empty buffer and is ignored
    read_en    = 1'b1;
    credit_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      in_data_valid = 1'b1;
      in_data       = i;
      if (i > 0) chk("stream_head", out_data, i - 1);
      tick();
      if (upstream_credit) credit_cnt++;
      if (i == 0) chk("stream_empty_rd_credit", upstream_credit, 0);
      chk("stream_occ", occupancy, 1);
    end
    in_data_valid = 1'b0;
    chk("stream_last_head", out_data, 19);
    tick();
    if (upstream_credit) credit_cnt++;
    read_en = 1'b0;
    chk("stream_end_occ", occupancy, 0);
    tick();
    if (upstream_credit) credit_cnt++;
    chk("stream_credits", credit_cnt, 20);

    // Asynchronous reset mid-operation with a read pending
    for (int i = 0; i < 3; i++) write_flit(32'hC0 + i);
    chk("mrst_pre_occ", occupancy, 3);
    read_en = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    chk("mrst_occ", occupancy, 0);
    chk("mrst_valid", out_data_valid, 0);
    chk("mrst_credit", upstream_credit, 0);
    chk("mrst_ovf", overflow_err, 0);
    tick();
    chk("mrst_hold_credit", upstream_credit, 0);
    rst = 1'b1;
    tick();
    chk("mrst_post_credit", upstream_credit, 0);
    chk("mrst_post_occ", occupancy, 0);
    tick();
    chk("mrst_post_credit2", upstream_credit, 0);
    read_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
